// File: rtl/clock_period_meter.sv
// Measures the period (and optionally the high time) of an asynchronous square wave in clk_in cycles.
// Optional high-time capture is enabled by defining CLOCK_PERIOD_METER_HIGH_TIME_EN.
module clock_period_meter #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 2**24-1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, MEASURE, STALLED} state_t;

  state_t           state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             s, prev, rise;
  logic [CNT_W-1:0] cnt;
  logic             at_timeout;
  logic             sample, enter_stall, leave_stall;

  assign s          = sync_q[SYNC_STAGES-1];
  assign rise       = s & ~prev;
  assign at_timeout = (cnt == TIMEOUT_C);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev   <= s;
    end
  end

  // Counter restarts at 1 on every rise so it equals the period when the next rise arrives.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (rise)
      cnt <= CNT_W'(1);
    else if (!at_timeout)
      cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    sample      = 1'b0;
    enter_stall = 1'b0;
    leave_stall = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = MEASURE;
        end else if (at_timeout) begin
          state_nxt   = STALLED;
          enter_stall = 1'b1;
        end
      end
      MEASURE: begin
        // A rise on the timeout cycle still completes a valid period.
        if (rise) begin
          sample = 1'b1;
        end else if (at_timeout) begin
          state_nxt   = STALLED;
          enter_stall = 1'b1;
        end
      end
      STALLED: begin
        if (rise) begin
          state_nxt   = MEASURE;
          leave_stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      period_out <= '0;
      valid      <= 1'b0;
      stalled    <= 1'b0;
    end else begin
      valid <= sample;
      if (sample)
        period_out <= cnt;
      if (enter_stall)
        stalled <= 1'b1;
      else if (leave_stall)
        stalled <= 1'b0;
    end
  end

`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
  logic             fall;
  logic [CNT_W-1:0] hcap, high_q;

  assign fall = ~s & prev;

  // hcap clears on every rise, so a period without a fall reports a high time of 0.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hcap   <= '0;
      high_q <= '0;
    end else begin
      if (rise)
        hcap <= '0;
      else if (fall && state == MEASURE)
        hcap <= cnt;
      if (sample)
        high_q <= hcap;
    end
  end

  assign high_out = high_q;
`else
  assign high_out = '0;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed testbench for clock_period_meter (TIMEOUT=50), sig_in driven synchronously just after posedge.
// Expected high times follow CLOCK_PERIOD_METER_HIGH_TIME_EN when it is defined for the build.
module tb_clock_period_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 50;
`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
  localparam bit HT_EN = 1'b1;
`else
  localparam bit HT_EN = 1'b0;
`endif

  logic             clk_in = 1'b0;
  logic             rst;
  logic             sig_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             valid;
  logic             stalled;

  int vectors    = 0;
  int miscompares = 0;

  // Monitor state: cumulative counts so the stimulus process can take deltas.
  int               valid_total  = 0;
  int               double_total = 0;
  int               bad_total    = 0;
  logic [CNT_W-1:0] last_period  = '0;
  logic [CNT_W-1:0] last_high    = '0;
  logic             prev_valid   = 1'b0;
  int               exp_lo = 0;
  int               exp_hi = 0;
  int               base_v, base_bad;

  clock_period_meter #(
    .CNT_W(CNT_W),
    .SYNC_STAGES(2),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .sig_in(sig_in),
    .period_out(period_out),
    .high_out(high_out),
    .valid(valid),
    .stalled(stalled)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (valid) begin
      valid_total = valid_total + 1;
      last_period = period_out;
      last_high   = high_out;
      if (int'(period_out) < exp_lo || int'(period_out) > exp_hi)
        bad_total = bad_total + 1;
      if (prev_valid)
        double_total = double_total + 1;
    end
    prev_valid = valid;
  end

  task automatic applyStimulus(input logic v, input int n);
    sig_in = v;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors = vectors + 1;
    assert (observed === expected)
    else begin
      miscompares = miscompares + 1;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    rst    = 1'b1;
    sig_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("reset_period", 32'(period_out), 0);
    checkOutput("reset_high", 32'(high_out), 0);
    checkOutput("reset_valid", 32'(valid), 0);
    checkOutput("reset_stalled", 32'(stalled), 0);
    rst = 1'b0;
    applyStimulus(1'b0, 3);

    $display("[TB] divider pattern 5/5");
    exp_lo = 10; exp_hi = 10;
    base_v = valid_total; base_bad = bad_total;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 5);
      applyStimulus(1'b0, 5);
    end
    checkOutput("div_valid_count", 32'(valid_total - base_v), 5);
    checkOutput("div_bad_period", 32'(bad_total - base_bad), 0);
    checkOutput("div_period", 32'(period_out), 10);
    checkOutput("div_high", 32'(last_high), HT_EN ? 32'd5 : 32'd0);

    $display("[TB] hand pattern 3/4");
    exp_lo = 10; exp_hi = 10;
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 4);
    checkOutput("switch_period", 32'(last_period), 10);
    exp_lo = 7; exp_hi = 7;
    base_v = valid_total; base_bad = bad_total;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 3);
      applyStimulus(1'b0, 4);
    end
    checkOutput("hand_valid_count", 32'(valid_total - base_v), 4);
    checkOutput("hand_bad_period", 32'(bad_total - base_bad), 0);
    checkOutput("hand_period", 32'(period_out), 7);
    checkOutput("hand_high", 32'(high_out), HT_EN ? 32'd3 : 32'd0);

    $display("[TB] stall after last rise");
    base_v = valid_total; base_bad = bad_total;
    applyStimulus(1'b1, 3);
    checkOutput("latency_valid", 32'(valid), 1);
    applyStimulus(1'b0, 49);
    checkOutput("stall_early", 32'(stalled), 0);
    applyStimulus(1'b0, 1);
    checkOutput("stall_exact", 32'(stalled), 1);
    applyStimulus(1'b0, 20);
    checkOutput("stall_hold", 32'(stalled), 1);
    checkOutput("stall_period_hold", 32'(period_out), 7);
    checkOutput("stall_no_valid", 32'(valid_total - base_v), 1);
    applyStimulus(1'b1, 3);
    checkOutput("unstall_cleared", 32'(stalled), 0);
    checkOutput("unstall_no_valid", 32'(valid), 0);
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 3);
    checkOutput("post_stall_valid", 32'(valid), 1);
    checkOutput("post_stall_period", 32'(period_out), 7);
    checkOutput("post_stall_high", 32'(high_out), HT_EN ? 32'd3 : 32'd0);

    $display("[TB] rise on timeout cycle");
    applyStimulus(1'b0, 47);
    checkOutput("stall_seq_valids", 32'(valid_total - base_v), 2);
    checkOutput("stall_seq_bad", 32'(bad_total - base_bad), 0);
    exp_lo = 50; exp_hi = 50;
    applyStimulus(1'b1, 3);
    checkOutput("edge_valid", 32'(valid), 1);
    checkOutput("edge_period", 32'(period_out), 50);
    checkOutput("edge_stalled", 32'(stalled), 0);
    checkOutput("edge_high", 32'(high_out), HT_EN ? 32'd3 : 32'd0);

    $display("[TB] reset mid-period");
    applyStimulus(1'b0, 4);
    rst = 1'b1;
    #2;
    checkOutput("midrst_period", 32'(period_out), 0);
    checkOutput("midrst_high", 32'(high_out), 0);
    checkOutput("midrst_valid", 32'(valid), 0);
    checkOutput("midrst_stalled", 32'(stalled), 0);
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    exp_lo = 7; exp_hi = 7;
    base_v = valid_total;
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 3);
    checkOutput("first_rise_valid", 32'(valid), 0);
    checkOutput("first_rise_period", 32'(period_out), 0);
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 3);
    checkOutput("second_rise_valid", 32'(valid), 1);
    checkOutput("second_rise_period", 32'(period_out), 7);
    applyStimulus(1'b0, 1);
    checkOutput("after_rst_valids", 32'(valid_total - base_v), 1);

    $display("[TB] glitch then period 8");
    exp_lo = 5; exp_hi = 8;
    base_v = valid_total; base_bad = bad_total;
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 4);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 4);
      applyStimulus(1'b0, 4);
    end
    checkOutput("glitch_valid_count", 32'(valid_total - base_v), 6);
    checkOutput("glitch_bad_period", 32'(bad_total - base_bad), 0);
    checkOutput("glitch_last_period", 32'(last_period), 8);
    checkOutput("glitch_high", 32'(high_out), HT_EN ? 32'd4 : 32'd0);
    checkOutput("valid_never_double", 32'(double_total), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
